mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 255, max BUSY cycles waiting for dm_ready before abort (8-bit counter).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 in_pc / in_mem_op / in_mem_addr / in_mem_data  in  32/4/32/32  from EXE_MEM register.
REQ-005 in_we / in_write_reg / in_write_data  in  1/5/32  register-writeback request from EXE_MEM.
REQ-006 dm_req / dm_wen  out  1/1  data-memory request and write enable.
REQ-007 dm_addr / dm_wdata / dm_be  out  32/32/4  word-aligned address, lane-replicated write data, byte enables.
REQ-008 dm_rdata / dm_ready  in  32/1  read word and completion strobe.
REQ-009 wb_pc / wb_we / wb_write_reg / wb_write_data  out  32/1/5/32  registered outputs to MEM_WB.
REQ-010 stall_req  out  1  combinational; holds upstream stages while high.
REQ-011 misalign_exc / bus_err  out  1/1  registered one-cycle error pulses.

Function
REQ-012 mem_op codes SHALL be: NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; codes 9-15 SHALL behave as NOP.
REQ-013 FSM states SHALL be IDLE and BUSY only.
REQ-014 IDLE with NOP: at edge, wb_* SHALL take in_pc/in_we/in_write_reg/in_write_data (1-cycle pass-through); stall_req=0.
REQ-015 Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL issue no request, pulse misalign_exc next cycle, drive wb_we=0, keep stall_req=0.
REQ-016 IDLE with aligned access: stall_req=1; at edge SHALL capture op, addr, data, pc, in_we, in_write_reg, go BUSY, clear counter, write wb_we=0 (bubble).
REQ-017 BUSY: dm_req=1, dm_wen=1 for SB/SH/SW else 0; dm_addr={addr[31:2],2'b00}; request fields constant until exit.
REQ-018 Store lanes: SB be=1<<addr[1:0], wdata=byte x4; SH be=0011 (addr[1]=0) or 1100, wdata=half x2; SW be=1111; loads be=1111.
REQ-019 BUSY stall_req SHALL equal !dm_ready; upstream advances on the completing edge.
REQ-020 dm_ready=1 in BUSY: at edge return IDLE; load: wb_we=captured in_we, wb_write_reg=captured reg, wb_write_data=selected lane (byte at addr[1:0]*8, half at addr[1]*16) sign-extended (LB/LH) or zero-extended (LBU/LHU/LW); store: wb_we=0.
REQ-021 Counter SHALL increment each BUSY cycle without dm_ready; reaching TIMEOUT SHALL return IDLE, pulse bus_err, drive wb_we=0, deassert stall_req that cycle.
REQ-022 dm_ready and dm_rdata SHALL be ignored in IDLE.
REQ-023 dm_ready coinciding with timeout expiry SHALL count as completion; no bus_err.
REQ-024 Minimum memory-op latency SHALL be 2 cycles (request edge + completion edge); back-to-back accesses SHALL insert no further bubble.

Reset
REQ-025 rst low SHALL immediately force IDLE, counter 0, dm_req=0, dm_wen=0, dm_be=0, dm_addr=0, dm_wdata=0, all wb_* 0, misalign_exc=0, bus_err=0.
REQ-026 rst asserted during BUSY SHALL abandon the access with no writeback and no error pulse.

Verification
REQ-027 NOP, in_we=1, reg=5, data=0x1234 -> next cycle wb_we=1, wb_write_reg=5, wb_write_data=0x1234, stall_req=0.
REQ-028 LB addr 0x103, dm_rdata=0x80FFFFFF, dm_ready after 3 BUSY cycles -> dm_addr=0x100, stall high 4 cycles, wb_write_data=0xFFFFFF80.
REQ-029 SH addr 0x22, data=0x0000BEEF -> dm_be=1100, dm_wdata=0xBEEFBEEF, dm_wen=1, wb_we=0.
REQ-030 LW addr 0x6 -> dm_req never high, misalign_exc one cycle, wb_we=0.
REQ-031 SW, dm_ready never asserted -> bus_err pulse after 255 BUSY cycles, FSM IDLE, stall_req low.
REQ-032 rst low mid-BUSY -> dm_req drops asynchronously; after release, NOP pass-through resumes normally.

Source files
------------

// File: rtl/mem_access.sv
// MEM stage data-memory access unit: issues one request per load/store, waits for dm_ready
// (bounded by TIMEOUT) and produces the registered MEM_WB writeback with lane-extracted data.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_pc,
  input  logic [3:0]  in_mem_op,
  input  logic [31:0] in_mem_addr,
  input  logic [31:0] in_mem_data,
  input  logic        in_we,
  input  logic [4:0]  in_write_reg,
  input  logic [31:0] in_write_data,
  output logic        dm_req,
  output logic        dm_wen,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic [31:0] wb_pc,
  output logic        wb_we,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_write_data,
  output logic        stall_req,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLh  = 4'd2;
  localparam logic [3:0] OpLw  = 4'd3;
  localparam logic [3:0] OpLbu = 4'd4;
  localparam logic [3:0] OpLhu = 4'd5;
  localparam logic [3:0] OpSb  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSw  = 4'd8;

  // Counter value seen on the last BUSY cycle before the access is aborted.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] pc_q;
  logic        we_q;
  logic [4:0]  reg_q;

  logic        in_is_mem;
  logic        in_misalign;
  logic        busy;
  logic        is_load_q;
  logic        is_store_q;
  logic        timeout_hit;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  assign in_is_mem   = (in_mem_op >= OpLb) && (in_mem_op <= OpSw);
  assign in_misalign = (((in_mem_op == OpLh) || (in_mem_op == OpLhu) || (in_mem_op == OpSh)) &&
                        in_mem_addr[0]) ||
                       (((in_mem_op == OpLw) || (in_mem_op == OpSw)) &&
                        (in_mem_addr[1:0] != 2'b00));

  assign busy        = (state_q == StBusy);
  assign is_load_q   = (op_q >= OpLb) && (op_q <= OpLhu);
  assign is_store_q  = (op_q >= OpSb) && (op_q <= OpSw);
  assign timeout_hit = (cnt_q == CntLast);

  // On the expiring cycle the stall drops so upstream advances in step with the abort.
  assign stall_req = busy ? (!dm_ready && !timeout_hit) : (in_is_mem && !in_misalign);

  assign dm_req  = busy;
  assign dm_wen  = busy && is_store_q;
  assign dm_addr = busy ? {addr_q[31:2], 2'b00} : 32'h0;

  always_comb begin
    dm_be    = 4'h0;
    dm_wdata = 32'h0;
    if (busy) begin
      unique case (op_q)
        OpSb: begin
          dm_be    = 4'b0001 << addr_q[1:0];
          dm_wdata = {4{data_q[7:0]}};
        end
        OpSh: begin
          dm_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          dm_wdata = {2{data_q[15:0]}};
        end
        OpSw: begin
          dm_be    = 4'b1111;
          dm_wdata = data_q;
        end
        default: dm_be = 4'b1111;
      endcase
    end
  end

  assign lane_byte = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_half = dm_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_data = dm_rdata;
    unique case (op_q)
      OpLb:    load_data = {{24{lane_byte[7]}}, lane_byte};
      OpLh:    load_data = {{16{lane_half[15]}}, lane_half};
      OpLbu:   load_data = {24'h0, lane_byte};
      OpLhu:   load_data = {16'h0, lane_half};
      default: load_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= 8'h0;
      op_q          <= 4'h0;
      addr_q        <= 32'h0;
      data_q        <= 32'h0;
      pc_q          <= 32'h0;
      we_q          <= 1'b0;
      reg_q         <= 5'h0;
      wb_pc         <= 32'h0;
      wb_we         <= 1'b0;
      wb_write_reg  <= 5'h0;
      wb_write_data <= 32'h0;
      misalign_exc  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      case (state_q)
        StIdle: begin
          wb_pc         <= in_pc;
          wb_write_reg  <= in_write_reg;
          wb_write_data <= in_write_data;
          if (in_misalign) begin
            wb_we        <= 1'b0;
            misalign_exc <= 1'b1;
          end else if (in_is_mem) begin
            wb_we   <= 1'b0;
            op_q    <= in_mem_op;
            addr_q  <= in_mem_addr;
            data_q  <= in_mem_data;
            pc_q    <= in_pc;
            we_q    <= in_we;
            reg_q   <= in_write_reg;
            cnt_q   <= 8'h0;
            state_q <= StBusy;
          end else begin
            wb_we <= in_we;
          end
        end
        StBusy: begin
          if (dm_ready) begin
            state_q       <= StIdle;
            wb_pc         <= pc_q;
            wb_we         <= is_load_q && we_q;
            wb_write_reg  <= reg_q;
            wb_write_data <= load_data;
          end else if (timeout_hit) begin
            state_q <= StIdle;
            wb_we   <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            wb_we <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: the driver pushes per-cycle expectations from a reference
// model, a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_access;

  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_pc = '0, in_mem_addr = '0, in_mem_data = '0, in_write_data = '0;
  logic [3:0]  in_mem_op = '0;
  logic        in_we = 1'b0;
  logic [4:0]  in_write_reg = '0;
  logic        dm_req, dm_wen;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata = '0;
  logic        dm_ready = 1'b0;
  logic [31:0] wb_pc, wb_write_data;
  logic        wb_we;
  logic [4:0]  wb_write_reg;
  logic        stall_req, misalign_exc, bus_err;

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_pc(in_pc), .in_mem_op(in_mem_op), .in_mem_addr(in_mem_addr), .in_mem_data(in_mem_data),
    .in_we(in_we), .in_write_reg(in_write_reg), .in_write_data(in_write_data),
    .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .wb_pc(wb_pc), .wb_we(wb_we), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .stall_req(stall_req), .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    int          due;
    bit          req;
    bit          wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          stall;
  } cyc_t;

  typedef struct {
    int          due;
    bit          full;
    bit          we;
    logic [4:0]  rg;
    logic [31:0] data;
    logic [31:0] pc;
    bit          mis;
    bit          berr;
  } wb_t;

  cyc_t cyc_q[$];
  wb_t  wb_q[$];

  task automatic push_cyc(bit req, bit wen, logic [31:0] a, logic [3:0] be, logic [31:0] wd,
                          bit stall);
    cyc_t e;
    e.due = cyc; e.req = req; e.wen = wen; e.addr = a; e.be = be; e.wdata = wd; e.stall = stall;
    cyc_q.push_back(e);
  endtask

  task automatic push_wb(bit full, bit we, logic [4:0] rg, logic [31:0] d, logic [31:0] pc,
                         bit mis, bit berr);
    wb_t e;
    e.due = cyc + 1; e.full = full; e.we = we; e.rg = rg; e.data = d; e.pc = pc;
    e.mis = mis; e.berr = berr;
    wb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (cyc_q.size() > 0 && cyc_q[0].due == cyc) begin
        cyc_t e;
        e = cyc_q.pop_front();
        chk("stall_req", 32'(stall_req), 32'(e.stall));
        chk("dm_req", 32'(dm_req), 32'(e.req));
        if (e.req) begin
          chk("dm_wen", 32'(dm_wen), 32'(e.wen));
          chk("dm_addr", dm_addr, e.addr);
          chk("dm_be", 32'(dm_be), 32'(e.be));
          if (e.wen) chk("dm_wdata", dm_wdata, e.wdata);
        end
      end
      if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
        wb_t w;
        w = wb_q.pop_front();
        chk("wb_we", 32'(wb_we), 32'(w.we));
        chk("misalign_exc", 32'(misalign_exc), 32'(w.mis));
        chk("bus_err", 32'(bus_err), 32'(w.berr));
        if (w.full) begin
          chk("wb_write_reg", 32'(wb_write_reg), 32'(w.rg));
          chk("wb_write_data", wb_write_data, w.data);
          chk("wb_pc", wb_pc, w.pc);
        end
      end
    end
  end

  // Reference model: 0 = pass-through, 1 = misaligned, 2 = memory access.
  function automatic int classify(int op, logic [31:0] addr);
    if (op < 1 || op > 8) return 0;
    if ((op == 2 || op == 5 || op == 7) && (addr % 2 != 0)) return 1;
    if ((op == 3 || op == 8) && (addr % 4 != 0)) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] ref_load(int op, logic [31:0] addr, logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> ((addr % 4) * 8)) % 256;
    h = (rdata >> (((addr % 4) / 2) * 16)) % 65536;
    case (op)
      1:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      2:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4:       return b;
      5:       return h;
      default: return rdata;
    endcase
  endfunction

  task automatic ref_store(int op, logic [31:0] addr, logic [31:0] data,
                           output logic [3:0] be, output logic [31:0] wd);
    be = 4'hF;
    wd = 32'h0;
    if (op == 6) begin
      be = 4'(1 << (addr % 4));
      wd = (data % 256) * 32'h0101_0101;
    end else if (op == 7) begin
      be = ((addr % 4) >= 2) ? 4'hC : 4'h3;
      wd = (data % 65536) * 32'h0001_0001;
    end else if (op == 8) begin
      wd = data;
    end
  endtask

  task automatic check_reset_values();
    chk("rst dm_req", 32'(dm_req), 0);
    chk("rst dm_wen", 32'(dm_wen), 0);
    chk("rst dm_be", 32'(dm_be), 0);
    chk("rst dm_addr", dm_addr, 0);
    chk("rst dm_wdata", dm_wdata, 0);
    chk("rst wb_we", 32'(wb_we), 0);
    chk("rst wb_pc", wb_pc, 0);
    chk("rst wb_write_reg", 32'(wb_write_reg), 0);
    chk("rst wb_write_data", wb_write_data, 0);
    chk("rst misalign_exc", 32'(misalign_exc), 0);
    chk("rst bus_err", 32'(bus_err), 0);
    chk("rst stall_req", 32'(stall_req), 0);
  endtask

  // Asynchronous reset in the middle of a cycle, then release after the next edge.
  task automatic mid_reset();
    in_mem_op = 4'h0;
    in_we     = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_values();
    cyc_q.delete();
    wb_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // d = BUSY cycles without dm_ready before the completing one; abort_at >= 0 resets mid-BUSY.
  task automatic issue(int op, logic [31:0] addr, logic [31:0] data, logic [31:0] pc, bit we,
                       logic [4:0] rg, logic [31:0] wdata_reg, int d, logic [31:0] rdata,
                       int abort_at);
    int          kind;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          st, ld;
    @(posedge clk);
    #1;
    in_mem_op = 4'(op); in_mem_addr = addr; in_mem_data = data; in_pc = pc;
    in_we = we; in_write_reg = rg; in_write_data = wdata_reg;
    dm_ready = 1'($urandom_range(0, 1));
    dm_rdata = $urandom;
    kind = classify(op, addr);
    if (kind == 0) begin
      push_cyc(0, 0, 0, 0, 0, 0);
      push_wb(1, we, rg, wdata_reg, pc, 0, 0);
      return;
    end
    if (kind == 1) begin
      push_cyc(0, 0, 0, 0, 0, 0);
      push_wb(0, 0, 0, 0, 0, 1, 0);
      return;
    end
    push_cyc(0, 0, 0, 0, 0, 1);
    push_wb(0, 0, 0, 0, 0, 0, 0);
    ref_store(op, addr, data, be, wd);
    st = (op >= 6);
    ld = !st;
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      @(posedge clk);
      #1;
      // Upstream contents are irrelevant once captured.
      in_mem_op = 4'($urandom); in_mem_addr = $urandom; in_mem_data = $urandom;
      in_pc = $urandom; in_we = 1'($urandom_range(0, 1)); in_write_reg = 5'($urandom);
      in_write_data = $urandom;
      if (k == abort_at) begin
        mid_reset();
        return;
      end
      dm_ready = (k == d);
      dm_rdata = (k == d) ? rdata : $urandom;
      if (k == d) begin
        push_cyc(1, st, (addr / 4) * 4, be, wd, 0);
        push_wb(ld, ld && we, rg, ref_load(op, addr, rdata), pc, 0, 0);
        return;
      end
      push_cyc(1, st, (addr / 4) * 4, be, wd, k != int'(TIMEOUT) - 1);
      push_wb(0, 0, 0, 0, 0, 0, k == int'(TIMEOUT) - 1);
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 check_reset_values();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    issue(0, 32'h0, 32'h0, 32'h1000, 1, 5'd5, 32'h1234, 0, 0, -1);
    issue(1, 32'h103, 32'h0, 32'h1004, 1, 5'd7, 32'h0, 3, 32'h80FF_FFFF, -1);
    issue(7, 32'h22, 32'h0000_BEEF, 32'h1008, 1, 5'd9, 32'h0, 1, 32'h0, -1);
    issue(3, 32'h6, 32'h0, 32'h100C, 1, 5'd3, 32'h0, 0, 0, -1);
    issue(0, 32'h0, 32'h0, 32'h1010, 0, 5'd1, 32'h55, 0, 0, -1);
    issue(8, 32'h40, 32'hCAFE_F00D, 32'h1014, 0, 5'd0, 32'h0, 1000, 0, -1);
    issue(4, 32'h41, 32'h0, 32'h1018, 1, 5'd12, 32'h0, int'(TIMEOUT) - 1, 32'h1234_9A78, -1);
    issue(12, 32'h3, 32'h0, 32'h101C, 1, 5'd31, 32'hDEAD_BEEF, 0, 0, -1);
    issue(3, 32'h80, 32'h0, 32'h1020, 1, 5'd4, 32'h0, 6, 32'h1111_2222, 2);
    issue(0, 32'h0, 32'h0, 32'h1024, 1, 5'd6, 32'h6666, 0, 0, -1);
    issue(0, 32'h0, 32'h0, 32'h1028, 1, 5'd8, 32'h7777, 0, 0, -1);

    for (int i = 0; i < 80; i++) begin
      issue($urandom_range(0, 15), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
            5'($urandom), $urandom, $urandom_range(0, 4), $urandom, -1);
    end

    issue(0, 32'h0, 32'h0, 32'h2000, 0, 5'd0, 32'h0, 0, 0, -1);
    issue(0, 32'h0, 32'h0, 32'h2004, 0, 5'd0, 32'h0, 0, 0, -1);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", 32'(wb_q.size() + cyc_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
